// File: rtl/alu_issue_ctrl_if.sv
// Instruction/result handshake bundle between the instruction source (master)
// and alu_issue_ctrl (slave).
interface alu_issue_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_err;

    modport master (
        output instr_valid,
        output instr,
        input  instr_ready,
        input  res_valid,
        input  res_data,
        input  res_err
    );

    modport slave (
        input  instr_valid,
        input  instr,
        output instr_ready,
        output res_valid,
        output res_data,
        output res_err
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the combinational ALU: decodes instructions,
// reads an 8x32 register file, drives the ALU and writes results back.
// Optional feature macro: ALU_ISSUE_IMM_EN (instr[10] selects zero-extended imm10 as operand 2).
module alu_issue_ctrl #(
    parameter int NREGS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_issue_ctrl_if.slave      ibus,
    input  logic                 load_en,
    input  logic [2:0]           load_addr,
    input  logic [31:0]          load_data,
    output logic [31:0]          alu_in1,
    output logic [31:0]          alu_in2,
    output logic [3:0]           alu_opcode,
    output logic [2:0]           alu_sr_cont,
    output logic [4:0]           alu_sr_bit,
    input  logic [31:0]          alu_out,
    input  logic [2:0]           dbg_addr,
    output logic [31:0]          dbg_data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DECODE = 2'd1;
    localparam logic [1:0] ST_EXEC   = 2'd2;
    localparam logic [1:0] ST_WB     = 2'd3;

    // Opcodes above 0101 have no ALU meaning.
    function automatic logic is_illegal(input logic [3:0] op);
        is_illegal = (op > 4'd5);
    endfunction

    logic [1:0]  state_r;
    logic [1:0]  next_state_s;
    logic        ready_r;
    logic        accept_s;
    logic [2:0]  rd_r;
    logic        illegal_r;
    logic [31:0] rf_r [NREGS];

    logic [3:0]  opcode_s;
    logic [2:0]  sr_cont_s;
    logic [4:0]  sr_bit_s;
    logic [2:0]  rd_s;
    logic [2:0]  rs1_s;
    logic [2:0]  rs2_s;
    logic [31:0] rs1_data_s;
    logic [31:0] rs2_data_s;
    logic [31:0] op2_s;

    logic [31:0] alu_in1_r;
    logic [31:0] alu_in2_r;
    logic [3:0]  alu_opcode_r;
    logic [2:0]  alu_sr_cont_r;
    logic [4:0]  alu_sr_bit_r;

    logic        res_valid_r;
    logic [31:0] res_data_r;
    logic        res_err_r;
    logic [31:0] dbg_data_s;

    assign opcode_s  = ibus.instr[31:28];
    assign sr_cont_s = ibus.instr[27:25];
    assign sr_bit_s  = ibus.instr[24:20];
    assign rd_s      = ibus.instr[19:17];
    assign rs1_s     = ibus.instr[16:14];
    assign rs2_s     = ibus.instr[13:11];

`ifdef ALU_ISSUE_IMM_EN
    logic       imm_flag_s;
    logic [9:0] imm10_s;
    assign imm_flag_s = ibus.instr[10];
    assign imm10_s    = ibus.instr[9:0];
`else
    logic [10:0] imm_unused_s;
    assign imm_unused_s = ibus.instr[10:0];
`endif

    // Handshake: an instruction is taken only while the controller is idle and ready.
    always_comb begin
        accept_s = 1'b0;
        if ((state_r == ST_IDLE) && ready_r && ibus.instr_valid) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Next-state logic: fixed four-cycle walk once an instruction is accepted.
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DECODE: next_state_s = ST_EXEC;
            ST_EXEC:   next_state_s = ST_WB;
            ST_WB:     next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // Register-file read ports; r0 is hard-wired to zero.
    always_comb begin
        rs1_data_s = 32'd0;
        rs2_data_s = 32'd0;
        dbg_data_s = 32'd0;
        if (rs1_s == 3'd0) begin
            rs1_data_s = 32'd0;
        end else begin
            rs1_data_s = rf_r[rs1_s];
        end
        if (rs2_s == 3'd0) begin
            rs2_data_s = 32'd0;
        end else begin
            rs2_data_s = rf_r[rs2_s];
        end
        if (dbg_addr == 3'd0) begin
            dbg_data_s = 32'd0;
        end else begin
            dbg_data_s = rf_r[dbg_addr];
        end
    end

    // Operand 2 source select.
    always_comb begin
        op2_s = rs2_data_s;
`ifdef ALU_ISSUE_IMM_EN
        if (imm_flag_s) begin
            op2_s = {22'd0, imm10_s};
        end else begin
            op2_s = rs2_data_s;
        end
`else
        op2_s = rs2_data_s;
`endif
    end

    // FSM state, ready flag and the per-instruction context kept until writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            ready_r   <= 1'b0;
            rd_r      <= 3'd0;
            illegal_r <= 1'b0;
        end else begin
            state_r <= next_state_s;
            ready_r <= (next_state_s == ST_IDLE);
            if (accept_s) begin
                rd_r      <= rd_s;
                illegal_r <= is_illegal(opcode_s);
            end
        end
    end

    // ALU drive registers: loaded as the instruction enters DECODE, held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_in1_r     <= 32'd0;
            alu_in2_r     <= 32'd0;
            alu_opcode_r  <= 4'd0;
            alu_sr_cont_r <= 3'd0;
            alu_sr_bit_r  <= 5'd0;
        end else if (accept_s) begin
            alu_in1_r     <= rs1_data_s;
            alu_in2_r     <= op2_s;
            alu_opcode_r  <= is_illegal(opcode_s) ? 4'd0 : opcode_s;
            alu_sr_cont_r <= sr_cont_s;
            alu_sr_bit_r  <= sr_bit_s;
        end
    end

    // Result capture at the end of EXEC; res_valid is therefore high exactly during WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r <= 1'b0;
            res_data_r  <= 32'd0;
            res_err_r   <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            res_valid_r <= 1'b1;
            res_data_r  <= illegal_r ? 32'd0 : alu_out;
            res_err_r   <= illegal_r;
        end else begin
            res_valid_r <= 1'b0;
            res_err_r   <= 1'b0;
        end
    end

    // Register file: writeback has priority; preload only when no instruction is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_r[i] <= 32'd0;
            end
        end else if (state_r == ST_WB) begin
            if (!illegal_r && (rd_r != 3'd0)) begin
                rf_r[rd_r] <= res_data_r;
            end
        end else if ((state_r == ST_IDLE) && !accept_s && load_en && (load_addr != 3'd0)) begin
            rf_r[load_addr] <= load_data;
        end
    end

    assign ibus.instr_ready = ready_r;
    assign ibus.res_valid   = res_valid_r;
    assign ibus.res_data    = res_data_r;
    assign ibus.res_err     = res_err_r;
    assign alu_in1          = alu_in1_r;
    assign alu_in2          = alu_in2_r;
    assign alu_opcode       = alu_opcode_r;
    assign alu_sr_cont      = alu_sr_cont_r;
    assign alu_sr_bit       = alu_sr_bit_r;
    assign dbg_data         = dbg_data_s;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU model on the ALU port.
module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic [2:0]  load_addr;
    logic [31:0] load_data;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [3:0]  alu_opcode;
    logic [2:0]  alu_sr_cont;
    logic [4:0]  alu_sr_bit;
    logic [31:0] alu_out;
    logic [2:0]  dbg_addr;
    logic [31:0] dbg_data;

    int checks = 0;
    int failures = 0;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ibus       (bus),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_opcode (alu_opcode),
        .alu_sr_cont(alu_sr_cont),
        .alu_sr_bit (alu_sr_bit),
        .alu_out    (alu_out),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: shift operand 2, then combine with operand 1.
    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [2:0] sc,
                                              input logic [4:0] sb);
        logic [31:0] s;
        case (sc)
            3'b001:  s = b >> sb;
            3'b010:  s = b << sb;
            3'b011:  s = $unsigned($signed(b) >>> sb);
            default: s = b;
        endcase
        case (op)
            4'd0:    alu_model = a + s;
            4'd1:    alu_model = a - s;
            4'd2:    alu_model = a & s;
            4'd3:    alu_model = a | s;
            4'd4:    alu_model = a ^ s;
            4'd5:    alu_model = s;
            default: alu_model = 32'd0;
        endcase
    endfunction

    always_comb alu_out = alu_model(alu_opcode, alu_in1, alu_in2, alu_sr_cont, alu_sr_bit);

    typedef struct {
        logic        ld_en;
        logic [2:0]  ld_addr;
        logic [31:0] ld_data;
        logic        ld_same;
        logic [31:0] instr;
        logic [31:0] e_in1;
        logic [31:0] e_in2;
        logic [3:0]  e_op;
        logic [31:0] e_res;
        logic        e_err;
        logic [2:0]  chk_addr;
        logic [31:0] e_reg;
    } vec_t;

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  op;
        logic [2:0]  sc;
        logic [4:0]  sb;
        logic [31:0] res;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[11];

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] sc, input logic [4:0] sb,
                                       input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic imm, input logic [9:0] imm10);
        mk = {op, sc, sb, rd, rs1, rs2, imm, imm10};
    endfunction

    function automatic vec_t mkvec(input logic ld_en, input logic [2:0] ld_addr, input logic [31:0] ld_data,
                                   input logic ld_same, input logic [31:0] instr,
                                   input logic [31:0] e_in1, input logic [31:0] e_in2, input logic [3:0] e_op,
                                   input logic [31:0] e_res, input logic e_err,
                                   input logic [2:0] chk_addr, input logic [31:0] e_reg);
        vec_t v;
        v.ld_en = ld_en; v.ld_addr = ld_addr; v.ld_data = ld_data; v.ld_same = ld_same;
        v.instr = instr; v.e_in1 = e_in1; v.e_in2 = e_in2; v.e_op = e_op;
        v.e_res = e_res; v.e_err = e_err; v.chk_addr = chk_addr; v.e_reg = e_reg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [2:0] addr, input logic [31:0] data);
        @(negedge clk);
        load_en = 1'b1; load_addr = addr; load_data = data;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        int   n;
        int   c;
        if (v.ld_en && !v.ld_same) preload(v.ld_addr, v.ld_data);
        @(negedge clk);
        n = 0;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("v%0d_ready", idx), {31'd0, bus.instr_ready}, 32'd1);
        e.in1 = v.e_in1; e.in2 = v.e_in2; e.op = v.e_op;
        e.sc = v.instr[27:25]; e.sb = v.instr[24:20];
        e.res = v.e_res; e.err = v.e_err;
        exp_q.push_back(e);
        bus.instr_valid = 1'b1;
        bus.instr = v.instr;
        dbg_addr = v.chk_addr;
        if (v.ld_en && v.ld_same) begin
            load_en = 1'b1; load_addr = v.ld_addr; load_data = v.ld_data;
        end
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        load_en = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_ready_low", idx), {31'd0, bus.instr_ready}, 32'd0);
        chk($sformatf("v%0d_alu_in1", idx), alu_in1, exp_q[0].in1);
        chk($sformatf("v%0d_alu_in2", idx), alu_in2, exp_q[0].in2);
        chk($sformatf("v%0d_alu_op", idx), {28'd0, alu_opcode}, {28'd0, exp_q[0].op});
        chk($sformatf("v%0d_alu_sc", idx), {29'd0, alu_sr_cont}, {29'd0, exp_q[0].sc});
        chk($sformatf("v%0d_alu_sb", idx), {27'd0, alu_sr_bit}, {27'd0, exp_q[0].sb});
        c = 1;
        while (!bus.res_valid && c < 10) begin
            @(negedge clk);
            c++;
        end
        chk($sformatf("v%0d_res_latency", idx), c, 32'd3);
        got = exp_q.pop_front();
        if (bus.res_valid) begin
            chk($sformatf("v%0d_res_data", idx), bus.res_data, got.res);
            chk($sformatf("v%0d_res_err", idx), {31'd0, bus.res_err}, {31'd0, got.err});
        end
        @(negedge clk);
        chk($sformatf("v%0d_res_pulse", idx), {31'd0, bus.res_valid}, 32'd0);
        chk($sformatf("v%0d_reg", idx), dbg_data, v.e_reg);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   seen;
        vec_t iv;
        rst_n = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr = 32'd0;
        load_en = 1'b0; load_addr = 3'd0; load_data = 32'd0;
        dbg_addr = 3'd0;

        // Table: r1=5, r2=7 preloaded before entry 0.
        vecs[0]  = mkvec(1'b0, 3'd0, 32'd0, 1'b0, mk(4'h0, 3'b000, 5'd0, 3'd3, 3'd1, 3'd2, 1'b0, 10'h155),
                         32'd5, 32'd7, 4'h0, 32'd12, 1'b0, 3'd3, 32'd12);
        vecs[1]  = mkvec(1'b1, 3'd2, 32'd1, 1'b0, mk(4'h1, 3'b010, 5'd4, 3'd4, 3'd1, 3'd2, 1'b0, 10'h0),
                         32'd5, 32'd1, 4'h1, 32'hFFFF_FFF5, 1'b0, 3'd4, 32'hFFFF_FFF5);
        vecs[2]  = mkvec(1'b0, 3'd0, 32'd0, 1'b0, mk(4'hA, 3'b000, 5'd0, 3'd5, 3'd1, 3'd2, 1'b0, 10'h0),
                         32'd5, 32'd1, 4'h0, 32'd0, 1'b1, 3'd5, 32'd0);
        vecs[3]  = mkvec(1'b0, 3'd0, 32'd0, 1'b0, mk(4'h0, 3'b000, 5'd0, 3'd0, 3'd3, 3'd4, 1'b0, 10'h0),
                         32'd12, 32'hFFFF_FFF5, 4'h0, 32'd1, 1'b0, 3'd0, 32'd0);
        vecs[4]  = mkvec(1'b0, 3'd0, 32'd0, 1'b0, mk(4'h2, 3'b000, 5'd0, 3'd6, 3'd3, 3'd1, 1'b0, 10'h0),
                         32'd12, 32'd5, 4'h2, 32'd4, 1'b0, 3'd6, 32'd4);
        vecs[5]  = mkvec(1'b0, 3'd0, 32'd0, 1'b0, mk(4'h3, 3'b000, 5'd0, 3'd7, 3'd4, 3'd3, 1'b0, 10'h0),
                         32'hFFFF_FFF5, 32'd12, 4'h3, 32'hFFFF_FFFD, 1'b0, 3'd7, 32'hFFFF_FFFD);
        vecs[6]  = mkvec(1'b0, 3'd0, 32'd0, 1'b0, mk(4'h4, 3'b001, 5'd1, 3'd2, 3'd1, 3'd6, 1'b0, 10'h0),
                         32'd5, 32'd4, 4'h4, 32'd7, 1'b0, 3'd2, 32'd7);
        vecs[7]  = mkvec(1'b0, 3'd0, 32'd0, 1'b0, mk(4'h5, 3'b110, 5'd3, 3'd1, 3'd0, 3'd2, 1'b0, 10'h0),
                         32'd0, 32'd7, 4'h5, 32'd7, 1'b0, 3'd1, 32'd7);
        vecs[8]  = mkvec(1'b0, 3'd0, 32'd0, 1'b0, mk(4'h6, 3'b000, 5'd0, 3'd3, 3'd1, 3'd2, 1'b0, 10'h0),
                         32'd7, 32'd7, 4'h0, 32'd0, 1'b1, 3'd3, 32'd12);
        vecs[9]  = mkvec(1'b0, 3'd0, 32'd0, 1'b0, mk(4'h1, 3'b011, 5'd4, 3'd5, 3'd0, 3'd4, 1'b0, 10'h0),
                         32'd0, 32'hFFFF_FFF5, 4'h1, 32'd1, 1'b0, 3'd5, 32'd1);
        vecs[10] = mkvec(1'b1, 3'd7, 32'h0000_DEAD, 1'b1, mk(4'hF, 3'b000, 5'd0, 3'd6, 3'd5, 3'd7, 1'b0, 10'h0),
                         32'd1, 32'hFFFF_FFFD, 4'h0, 32'd0, 1'b1, 3'd6, 32'd4);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, bus.instr_ready}, 32'd0);
        chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, bus.instr_ready}, 32'd1);

        preload(3'd1, 32'd5);
        preload(3'd2, 32'd7);
        preload(3'd0, 32'h0000_FFFF);
        @(negedge clk);
        dbg_addr = 3'd0;
        #1;
        chk("r0_preload", dbg_data, 32'd0);
        dbg_addr = 3'd1;
        #1;
        chk("r1_preload", dbg_data, 32'd5);

        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

        dbg_addr = 3'd7;
        #1;
        chk("r7_load_ignored", dbg_data, 32'hFFFF_FFFD);

        // Reset asserted while an instruction is in EXEC.
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr = mk(4'h0, 3'b000, 5'd0, 3'd3, 3'd1, 3'd2, 1'b0, 10'h0);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        chk("midrst_alu_in1", alu_in1, 32'd0);
        chk("midrst_ready", {31'd0, bus.instr_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.res_valid) seen++;
        end
        chk("midrst_no_result", seen, 32'd0);
        chk("midrst_ready_after", {31'd0, bus.instr_ready}, 32'd1);
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a);
            #1;
            chk($sformatf("midrst_r%0d", a), dbg_data, 32'd0);
        end

        // Immediate-operand instruction; result depends on the build.
        preload(3'd1, 32'd5);
        preload(3'd2, 32'h0000_0020);
`ifdef ALU_ISSUE_IMM_EN
        iv = mkvec(1'b0, 3'd0, 32'd0, 1'b0, mk(4'h0, 3'b000, 5'd0, 3'd3, 3'd1, 3'd2, 1'b1, 10'h3FF),
                   32'd5, 32'h0000_03FF, 4'h0, 32'h0000_0404, 1'b0, 3'd3, 32'h0000_0404);
`else
        iv = mkvec(1'b0, 3'd0, 32'd0, 1'b0, mk(4'h0, 3'b000, 5'd0, 3'd3, 3'd1, 3'd2, 1'b1, 10'h3FF),
                   32'd5, 32'h0000_0020, 4'h0, 32'h0000_0025, 1'b0, 3'd3, 32'h0000_0025);
`endif
        run_vec(iv, 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
